rv32i_decode_stage: RTL
=======================

// Module: rv32i_decode_stage
// PURPOSE
//  Decodes 32-bit RV32I instruction words into the operand and instruction-ID bundle the
//  ALU consumes: instr_id, register indices, sign-extended immediate, shamt and pc.
//  Sits between fetch and the ALU/regfile read stage as a registered pipeline stage.
//  Valid/ready handshaking on both sides; a skid buffer gives full throughput; flush supported.
// PARAMETERS
//  WIDTH       32     datapath width; imm is sign-extended to WIDTH
//  ILLEGAL_ID  6'h3F  instr_id emitted for undecodable words; must not match any `i_* code
// PORTS
//  clk        in   1      clock, all state on posedge
//  rst        in   1      asynchronous, active-low reset
//  flush      in   1      synchronous pipeline flush (redirect)
//  in_valid   in   1      fetch presents instr/pc
//  in_ready   out  1      stage can accept (registered)
//  instr      in   32     raw instruction word
//  pc_in      in   32     pc of instr
//  out_valid  out  1      decoded bundle valid
//  out_ready  in   1      consumer accepts bundle
//  instr_id   out  6      `i_* code from instructions.v, or ILLEGAL_ID
//  rs1_idx    out  5      instr[19:15]
//  rs2_idx    out  5      instr[24:20]
//  rd_idx     out  5      instr[11:7]
//  imm        out  WIDTH  format-selected immediate, sign-extended
//  shamt      out  5      instr[24:20] for slli/srli/srai, else 0
//  pc_out     out  32     pc of decoded instr
//  illegal    out  1      1 when instr_id == ILLEGAL_ID
// BEHAVIOUR
//  - Reset (rst=0, async): out_valid=0, skid empty, in_ready=1; every data output = 0.
//  - Accept on in_valid&in_ready; deliver on out_valid&out_ready. Latency: word accepted at
//    edge N appears on the outputs after edge N (1 cycle) if the output register is free.
//  - Output register + 1-entry skid. If out_valid&!out_ready and a word is accepted, it goes to
//    skid; in_ready<=0 while skid full. On delivery the skid moves to output, in_ready<=1.
//  - While out_valid&!out_ready all outputs hold stable. Order strictly preserved; no drop or dup.
//  - Simultaneous deliver+accept with skid empty: new word loads output directly (throughput 1/clk).
//  - flush=1: at the next edge out_valid=0, skid cleared, in_ready=1; any word accepted in that
//    same cycle is discarded. flush overrides all other updates.
//  - Decode uses opcode/funct3/funct7:
//    LUI/AUIPC U: {instr[31:12],12'b0}; JAL J: {instr[31],[19:12],[20],[30:21],1'b0};
//    JALR/loads/OP-IMM I: instr[31:20]; stores S: {[31:25],[11:7]};
//    branches B: {[31],[7],[30:25],[11:8],1'b0}. R-type: imm=0.
//  - SRAI/SUB/SRA need funct7=0100000; other R-type and SLLI/SRLI need funct7=0.
//  - Illegal: unknown opcode/funct3/funct7, shift-imm with instr[25]=1, FENCE/SYSTEM, instr[1:0]!=11.
//    Illegal gives instr_id=ILLEGAL_ID, illegal=1, imm=0, shamt=0; it still flows through the stage.
//  - Decode is combinational on input data and registered into the output/skid entry; no decode
//    logic sits after the output register.
// TESTING
//  1 reset low mid-stream -> out_valid=0, in_ready=1, outputs 0 immediately (async).
//  2 0xFFF10093 (addi x1,x2,-1) -> id=`i_addi, rd=1, rs1=2, imm=0xFFFFFFFF, 1 cycle later.
//  3 0x123452B7 (lui x5,0x12345) -> `i_lui, rd=5, imm=0x12345000; 0xFE000EE3 -> `i_beq, imm=0xFFFFFFFC.
//  4 stream 4 words, out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, all 4 out in order.
//  5 0x00000000 and 0x40001013 (slli, bit30 set) -> illegal=1, id=ILLEGAL_ID, imm=0.
//  6 flush during stall, skid full -> next cycle out_valid=0, in_ready=1, stalled words never out.

Source files
------------

// File: rtl/rv32i_decode_stage.sv
// RV32I decode pipeline stage: combinational decode into an output register backed by a
// one-entry skid buffer. ID codes: lui=0 auipc=1 jal=2 jalr=3 beq..bgeu=4..9 lb,lh,lw,lbu,lhu=10..14
// sb,sh,sw=15..17 addi,slti,sltiu,xori,ori,andi=18..23 slli,srli,srai=24..26
// add,sub,sll,slt,sltu,xor,srl,sra,or,and=27..36
module rv32i_decode_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [5:0]  ILLEGAL_ID = 6'h3F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       instr_id,
  output logic [4:0]       rs1_idx,
  output logic [4:0]       rs2_idx,
  output logic [4:0]       rd_idx,
  output logic [WIDTH-1:0] imm,
  output logic [4:0]       shamt,
  output logic [31:0]      pc_out,
  output logic             illegal
);

  localparam logic [5:0] IdLui   = 6'd0;
  localparam logic [5:0] IdAuipc = 6'd1;
  localparam logic [5:0] IdJal   = 6'd2;
  localparam logic [5:0] IdJalr  = 6'd3;
  localparam logic [5:0] IdBeq   = 6'd4;
  localparam logic [5:0] IdLb    = 6'd10;
  localparam logic [5:0] IdSb    = 6'd15;
  localparam logic [5:0] IdAddi  = 6'd18;
  localparam logic [5:0] IdSlli  = 6'd24;
  localparam logic [5:0] IdAdd   = 6'd27;

  typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_sel_e;

  typedef struct packed {
    logic [5:0]       id;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] imm;
    logic [31:0]      pc;
    logic             ill;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [5:0]  id_c;
  logic [4:0]  shamt_c;
  logic [31:0] imm32;
  imm_sel_e    imm_sel;
  bundle_t     dec;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    id_c    = ILLEGAL_ID;
    shamt_c = 5'd0;
    imm_sel = ImmNone;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        7'b0110111: begin id_c = IdLui;   imm_sel = ImmU; end
        7'b0010111: begin id_c = IdAuipc; imm_sel = ImmU; end
        7'b1101111: begin id_c = IdJal;   imm_sel = ImmJ; end
        7'b1100111: begin
          imm_sel = ImmI;
          if (funct3 == 3'b000) id_c = IdJalr;
        end
        7'b1100011: begin
          imm_sel = ImmB;
          case (funct3)
            3'b000:  id_c = IdBeq;
            3'b001:  id_c = IdBeq + 6'd1;
            3'b100:  id_c = IdBeq + 6'd2;
            3'b101:  id_c = IdBeq + 6'd3;
            3'b110:  id_c = IdBeq + 6'd4;
            3'b111:  id_c = IdBeq + 6'd5;
            default: id_c = ILLEGAL_ID;
          endcase
        end
        7'b0000011: begin
          imm_sel = ImmI;
          case (funct3)
            3'b000:  id_c = IdLb;
            3'b001:  id_c = IdLb + 6'd1;
            3'b010:  id_c = IdLb + 6'd2;
            3'b100:  id_c = IdLb + 6'd3;
            3'b101:  id_c = IdLb + 6'd4;
            default: id_c = ILLEGAL_ID;
          endcase
        end
        7'b0100011: begin
          imm_sel = ImmS;
          case (funct3)
            3'b000:  id_c = IdSb;
            3'b001:  id_c = IdSb + 6'd1;
            3'b010:  id_c = IdSb + 6'd2;
            default: id_c = ILLEGAL_ID;
          endcase
        end
        7'b0010011: begin
          imm_sel = ImmI;
          case (funct3)
            3'b000: id_c = IdAddi;
            3'b010: id_c = IdAddi + 6'd1;
            3'b011: id_c = IdAddi + 6'd2;
            3'b100: id_c = IdAddi + 6'd3;
            3'b110: id_c = IdAddi + 6'd4;
            3'b111: id_c = IdAddi + 6'd5;
            3'b001: if (funct7 == 7'b0000000) id_c = IdSlli;
            3'b101: begin
              if (funct7 == 7'b0000000)      id_c = IdSlli + 6'd1;
              else if (funct7 == 7'b0100000) id_c = IdSlli + 6'd2;
            end
            default: id_c = ILLEGAL_ID;
          endcase
          if (id_c != ILLEGAL_ID && (funct3 == 3'b001 || funct3 == 3'b101)) begin
            shamt_c = instr[24:20];
          end
        end
        7'b0110011: begin
          if (funct7 == 7'b0000000) begin
            case (funct3)
              3'b000: id_c = IdAdd;
              3'b001: id_c = IdAdd + 6'd2;
              3'b010: id_c = IdAdd + 6'd3;
              3'b011: id_c = IdAdd + 6'd4;
              3'b100: id_c = IdAdd + 6'd5;
              3'b101: id_c = IdAdd + 6'd6;
              3'b110: id_c = IdAdd + 6'd8;
              3'b111: id_c = IdAdd + 6'd9;
              default: id_c = ILLEGAL_ID;
            endcase
          end else if (funct7 == 7'b0100000) begin
            if (funct3 == 3'b000)      id_c = IdAdd + 6'd1;
            else if (funct3 == 3'b101) id_c = IdAdd + 6'd7;
          end
        end
        default: id_c = ILLEGAL_ID;
      endcase
    end
    if (id_c == ILLEGAL_ID) imm_sel = ImmNone;
  end

  always_comb begin
    imm32 = 32'd0;
    case (imm_sel)
      ImmI:    imm32 = {{20{instr[31]}}, instr[31:20]};
      ImmS:    imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      ImmB:    imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      ImmU:    imm32 = {instr[31:12], 12'd0};
      ImmJ:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  always_comb begin
    dec.id    = id_c;
    dec.rs1   = instr[19:15];
    dec.rs2   = instr[24:20];
    dec.rd    = instr[11:7];
    dec.shamt = shamt_c;
    dec.imm   = WIDTH'($signed(imm32));
    dec.pc    = pc_in;
    dec.ill   = (id_c == ILLEGAL_ID);
  end

  bundle_t out_q, out_d, skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    accept, deliver;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid_q & out_ready;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || deliver) begin
      // Output slot frees up: skid has priority so order is preserved.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign instr_id  = out_q.id;
  assign rs1_idx   = out_q.rs1;
  assign rs2_idx   = out_q.rs2;
  assign rd_idx    = out_q.rd;
  assign shamt     = out_q.shamt;
  assign imm       = out_q.imm;
  assign pc_out    = out_q.pc;
  assign illegal   = out_q.ill;

endmodule
